// File: rtl/exe_dm_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// exe_dm_pipe_reg_pkg
//
// Purpose:
//   Shared definitions for the EXE->DM elastic pipeline register of the
//   pipelined MIPS core. It holds the default payload widths, the control
//   bundle layout, and the occupancy state encoding.
//
// Contents:
//   DSIZE_DEF / ASIZE_DEF / ISIZE_DEF : default data, register-address and
//                                       nPC widths
//   CTRL_W_DEF                        : control bundle width
//   CTRL_WEN .. CTRL_JAL              : bit positions inside the control bundle,
//                                       order {jal, mem_to_reg, mem_write,
//                                       mem_read, wen}
//   occ_state_t                       : EMPTY / ONE (M) / FULL (M+S)
//   payloadWidth()                    : total stored bits per entry
// ---------------------------------------------------------------------------
package exe_dm_pipe_reg_pkg;

    // Default payload widths
    localparam int DSIZE_DEF  = 16;
    localparam int ASIZE_DEF  = 4;
    localparam int ISIZE_DEF  = 16;

    // Control bundle width and bit positions
    localparam int CTRL_W_DEF     = 5;
    localparam int CTRL_WEN       = 0;
    localparam int CTRL_MEM_READ  = 1;
    localparam int CTRL_MEM_WRITE = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_JAL       = 4;

    // Occupancy of the two-entry skid buffer. The main register M always
    // holds the oldest entry; S only ever holds a second, younger entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // Bits stored per entry: control, write address, ALU result,
    // store data and link value.
    function automatic int payloadWidth(input int ctrlW,
                                        input int aSize,
                                        input int dSize,
                                        input int iSize);
        return ctrlW + aSize + (2 * dSize) + iSize;
    endfunction

endpackage : exe_dm_pipe_reg_pkg

// File: rtl/exe_dm_pipe_reg_payload.sv
// ---------------------------------------------------------------------------
// pipe_payload_reg
//
// Purpose:
//   Plain width-parameterised register with a load enable and a synchronous
//   active-high reset. The EXE->DM stage uses two of these: the main
//   register M that drives the outputs, and the skid register S.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset, clears the contents
//   i_load in  1      capture i_d on the next rising edge
//   i_d    in  WIDTH  data to capture
//   o_q    out WIDTH  registered contents
// ---------------------------------------------------------------------------
module pipe_payload_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // The contents only change on an explicit load; validity is tracked by
    // the owner, so a flush never needs to touch this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_payload_reg

// File: rtl/exe_dm_pipe_reg.sv
// ---------------------------------------------------------------------------
// exe_dm_pipe_reg
//
// Purpose:
//   EXE->DM pipeline register of the pipelined MIPS core, built as a
//   valid/ready elastic stage with a two-entry skid buffer. in_ready comes
//   straight from a flop, so the ready path does not ripple back into EXE.
//   A synchronous flush squashes held entries and the current input for
//   branch/jump recovery. The control bundle is forced to zero whenever no
//   valid instruction is presented, so a bubble can never write memory or
//   the register file.
//
// Optional feature (macro PIPE_PERF_EN):
//   When defined, stall_cnt counts cycles with out_valid & ~out_ready and
//   bubble_cnt counts cycles with out_valid = 0. Both wrap and clear only
//   on rst. When undefined, no counter logic exists and both read 0.
//
// Ports:
//   clk            in  1       rising-edge clock
//   rst            in  1       synchronous active-high reset
//   flush          in  1       squash held entries and the current input
//   in_valid       in  1       EXE presents a valid instruction
//   in_ready       out 1       stage can accept (registered)
//   ctrl_in        in  CTRL_W  {jal, mem_to_reg, mem_write, mem_read, wen}
//   waddr_in       in  ASIZE   destination register
//   aluout_in      in  DSIZE   ALU result / memory address
//   read_data2_in  in  DSIZE   store data
//   nPC_in         in  ISIZE   PC+1 for jal link
//   out_valid      out 1       DM side holds a valid instruction
//   out_ready      in  1       DM side consumes this cycle
//   ctrl_out       out CTRL_W  control, zero when out_valid = 0
//   waddr_out      out ASIZE   destination register
//   aluout_out     out DSIZE   ALU result
//   read_data2_out out DSIZE   store data
//   nPC_out        out ISIZE   link value
//   stall_cnt      out 32      back-pressure cycles (PIPE_PERF_EN)
//   bubble_cnt     out 32      empty-output cycles (PIPE_PERF_EN)
// ---------------------------------------------------------------------------
module exe_dm_pipe_reg
    import exe_dm_pipe_reg_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int ASIZE  = ASIZE_DEF,
    parameter int ISIZE  = ISIZE_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ASIZE-1:0]  waddr_in,
    input  logic [DSIZE-1:0]  aluout_in,
    input  logic [DSIZE-1:0]  read_data2_in,
    input  logic [ISIZE-1:0]  nPC_in,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [ASIZE-1:0]  waddr_out,
    output logic [DSIZE-1:0]  aluout_out,
    output logic [DSIZE-1:0]  read_data2_out,
    output logic [ISIZE-1:0]  nPC_out,

    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
);

    localparam int PW = payloadWidth(CTRL_W, ASIZE, DSIZE, ISIZE);

    // -----------------------------------------------------------------------
    // Occupancy state and registered ready
    // -----------------------------------------------------------------------
    occ_state_t r_state;
    occ_state_t w_next_state;
    logic       r_in_ready;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_valid;

    logic w_load_m;
    logic w_load_s;
    logic w_m_from_s;

    logic [PW-1:0]     w_in_payload;
    logic [PW-1:0]     w_m_d;
    logic [PW-1:0]     w_m_q;
    logic [PW-1:0]     w_s_q;
    logic [CTRL_W-1:0] w_m_ctrl;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    assign w_in_payload = {ctrl_in, waddr_in, aluout_in, read_data2_in, nPC_in};

    // When draining from FULL the younger entry moves from S into M;
    // otherwise M only ever captures the incoming instruction.
    assign w_m_d = w_m_from_s ? w_s_q : w_in_payload;

    // State register. in_ready is registered from the next state, so it
    // equals (state != FULL) without any combinational path to out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Next-state and register-load decode. Flush wins over every transfer:
    // it only clears validity, the payload registers keep their contents.
    always_comb begin
        w_next_state = r_state;
        w_load_m     = 1'b0;
        w_load_s     = 1'b0;
        w_m_from_s   = 1'b0;

        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_m     = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_m     = 1'b1;
                        w_next_state = ST_ONE;
                    end else if (w_in_fire) begin
                        w_load_s     = 1'b1;
                        w_next_state = ST_FULL;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (w_out_fire) begin
                        w_load_m     = 1'b1;
                        w_m_from_s   = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end

                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Payload storage
    // -----------------------------------------------------------------------
    pipe_payload_reg #(
        .WIDTH (PW)
    ) u_main_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_m),
        .i_d    (w_m_d),
        .o_q    (w_m_q)
    );

    pipe_payload_reg #(
        .WIDTH (PW)
    ) u_skid_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_s),
        .i_d    (w_in_payload),
        .o_q    (w_s_q)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign {w_m_ctrl, waddr_out, aluout_out, read_data2_out, nPC_out} = w_m_q;

    // Only the control bundle is gated; data outputs show stale M contents
    // during bubbles, which is harmless once every enable is zero.
    assign ctrl_out  = w_out_valid ? w_m_ctrl : '0;
    assign out_valid = w_out_valid;
    assign in_ready  = r_in_ready;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Counters are cleared by reset only; a flush is ordinary pipeline
    // activity and must not hide the stalls or bubbles it causes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_out_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!w_out_valid) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule : exe_dm_pipe_reg

// File: tb/tb_exe_dm_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_exe_dm_pipe_reg
//
// Purpose:
//   Self-checking bench for exe_dm_pipe_reg. Directed vectors drive the EXE
//   side; every accepted instruction is pushed into a scoreboard queue and a
//   separate monitor pops and compares whenever the DM side consumes one.
//   Honors PIPE_PERF_EN when checking the performance counters.
// ---------------------------------------------------------------------------
module tb_exe_dm_pipe_reg;

    logic        clk;
    logic        rst = 1'b1;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ctrl_in;
    logic [3:0]  waddr_in;
    logic [15:0] aluout_in;
    logic [15:0] read_data2_in;
    logic [15:0] nPC_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ctrl_out;
    logic [3:0]  waddr_out;
    logic [15:0] aluout_out;
    logic [15:0] read_data2_out;
    logic [15:0] nPC_out;
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    logic [56:0] sbQ[$];

    exe_dm_pipe_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ctrl_in        (ctrl_in),
        .waddr_in       (waddr_in),
        .aluout_in      (aluout_in),
        .read_data2_in  (read_data2_in),
        .nPC_in         (nPC_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .ctrl_out       (ctrl_out),
        .waddr_out      (waddr_out),
        .aluout_out     (aluout_out),
        .read_data2_out (read_data2_out),
        .nPC_out        (nPC_out),
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, report it if it does not match
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Pack the full payload the way the bench expects to see it come out
    function automatic logic [56:0] mkPayload(input logic [4:0] c, input logic [15:0] a);
        return {c, a[3:0], a, a ^ 16'hFFFF, a + 16'h0100};
    endfunction

    // One cycle of stimulus. Called #1 after a rising edge; checks the
    // hand-derived out_valid / in_ready at the falling edge, then records
    // the instruction in the scoreboard if it should be accepted.
    task automatic applyStimulus(input logic v, input logic [4:0] c,
                                 input logic [15:0] a, input logic rdy,
                                 input logic fl, input logic expOV,
                                 input logic expRdy);
        in_valid      = v;
        ctrl_in       = c;
        waddr_in      = a[3:0];
        aluout_in     = a;
        read_data2_in = a ^ 16'hFFFF;
        nPC_in        = a + 16'h0100;
        out_ready     = rdy;
        flush         = fl;
        @(negedge clk);
        checkOutput("out_valid", {63'd0, out_valid}, {63'd0, expOV});
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expRdy});
        @(posedge clk);
        if (fl) begin
            sbQ.delete();
        end else if (v && expRdy) begin
            sbQ.push_back(mkPayload(c, a));
        end
        #1;
    endtask

    // Monitor: compares every consumed instruction against the scoreboard
    // and checks that the control bundle is zero on every bubble.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_delivery", 64'd1, 64'd0);
                end else begin
                    checkOutput("delivered_payload",
                                {7'd0, ctrl_out, waddr_out, aluout_out, read_data2_out, nPC_out},
                                {7'd0, sbQ.pop_front()});
                end
            end
            if (!out_valid) begin
                checkOutput("bubble_ctrl", {59'd0, ctrl_out}, 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] expStall;
        logic [31:0] expBubble;
`ifdef PIPE_PERF_EN
        expStall  = 32'd4;
        expBubble = 32'd3;
`else
        expStall  = 32'd0;
        expBubble = 32'd0;
`endif
        // Reset held two cycles while EXE drives a full-control instruction
        flush         = 1'b0;
        in_valid      = 1'b1;
        ctrl_in       = 5'h1F;
        waddr_in      = 4'hF;
        aluout_in     = 16'h1234;
        read_data2_in = 16'h5678;
        nPC_in        = 16'h9ABC;
        out_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_ctrl_out", {59'd0, ctrl_out}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_data", {12'd0, waddr_out, aluout_out, read_data2_out, nPC_out}, 64'd0);
        checkOutput("rst_counters", {stall_cnt, bubble_cnt}, 64'd0);
        rst = 1'b0;

        // Counters: three cycles with nothing valid, then four back-pressured
        //            v     ctrl      alu       rdy   fl    OV    RDY
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'b00011, 16'h0777, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        checkOutput("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, expBubble});
        checkOutput("stall_cnt", {32'd0, stall_cnt}, {32'd0, expStall});
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Streaming at one instruction per cycle
        applyStimulus(1'b1, 5'b00001, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'b01011, 16'h0011, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'b10001, 16'h0012, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-pressure: A accepted, B lands in the skid register
        applyStimulus(1'b1, 5'b00100, 16'h00A0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'b01011, 16'h00B0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'b01011, 16'h00B0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("full_holds_A", {48'd0, aluout_out}, 64'h00A0);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush while FULL, with C offered in the same cycle
        applyStimulus(1'b1, 5'b00001, 16'h00E0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'b00001, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 5'b00001, 16'h00C0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flushed store: mem_write never reaches DM, data stays visible
        applyStimulus(1'b1, 5'b00100, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("store_ctrl_valid", {59'd0, ctrl_out}, 64'h04);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bubble_mem_write", {63'd0, ctrl_out[2]}, 64'd0);
        checkOutput("bubble_data_kept", {48'd0, aluout_out}, 64'h005A);
        applyStimulus(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_exe_dm_pipe_reg
